controle_painel: RTL and testbench

CONTROLE_PAINEL -- requirements
Module: controle_painel

---
 rtl/controle_painel_pkg.sv | 28 ++
 rtl/controle_painel_divisor_tick.sv | 34 +++
 rtl/controle_painel.sv | 126 ++++++++++++
 tb/tb_controle_painel.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/controle_painel_pkg.sv
// Shared types, universal-register mode codes and the scrolling message table.
package controle_painel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Indexed TABLE[msg][frame]; each row lists frames 3..0 left to right.
  localparam logic [3:0][3:0][15:0] TABLE = {
    {16'h0FF0, 16'hF00F, 16'h3C3C, 16'hC3C3},
    {16'hB3F3, 16'hB2F2, 16'hB1F1, 16'hB0F0},
    {16'hA004, 16'hA003, 16'hA002, 16'hA001},
    {16'h4444, 16'h3333, 16'h2222, 16'h1111}
  };

  function automatic logic [15:0] msg_word(input logic [1:0] msg, input logic [1:0] frame);
    return TABLE[msg][frame];
  endfunction

endpackage

// File: rtl/controle_painel_divisor_tick.sv
// Shift-tick divider: counts 0..TICK_DIV-1, flags the terminal count, holds while frozen.
module divisor_tick #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter with clear over freeze, wrapping at the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (freeze) begin
      cnt_r <= cnt_r;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/controle_painel.sv
// Scrolling-panel controller: loads message frames into a 16-bit universal
// register and paces its shifts from the tick divider.
module controle_painel
  import controle_painel_pkg::*;
#(
  parameter int TICK_DIV         = 50000000,
  parameter int SHIFTS_PER_FRAME = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        dir,
  input  logic [1:0]  msg_sel,
  output logic        ch0,
  output logic        ch1,
  output logic [15:0] cadeiaDeBits,
  output logic        busy,
  output logic        frame_done
);

  localparam int SW = (SHIFTS_PER_FRAME > 1) ? $clog2(SHIFTS_PER_FRAME) : 1;
  localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFTS_PER_FRAME - 1);

  state_t        state_r;
  logic [SW-1:0] shift_cnt_r;
  logic [1:0]    frame_r;
  logic [1:0]    msg_r;
  logic [15:0]   word_r;

  logic       tick_s;
  logic       tick_ok_s;
  logic       last_shift_s;
  logic       div_clear_s;
  logic       div_freeze_s;
  logic [1:0] frame_next_s;
  logic [1:0] mode_s;

  assign div_clear_s  = (state_r == ST_LOAD);
  assign div_freeze_s = (state_r != ST_RUN) || pause || stop;
  // A tick only becomes a shift when nothing with higher priority claims the cycle.
  assign tick_ok_s    = (state_r == ST_RUN) && tick_s && !pause && !stop && !rst;
  assign last_shift_s = tick_ok_s && (shift_cnt_r == SHIFT_LAST);
  assign frame_next_s = frame_r + 2'd1;

  divisor_tick #(.TICK_DIV(TICK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clear  (div_clear_s),
    .freeze (div_freeze_s),
    .tick   (tick_s)
  );

  // Control FSM with frame index, shift counter and latched load word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shift_cnt_r <= '0;
      frame_r     <= 2'd0;
      msg_r       <= 2'd0;
      word_r      <= 16'h0000;
    end else if (stop) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            msg_r   <= msg_sel;
            frame_r <= 2'd0;
            word_r  <= msg_word(msg_sel, 2'd0);
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift_cnt_r <= '0;
          state_r     <= ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_r <= ST_PAUSED;
          end else if (last_shift_s) begin
            shift_cnt_r <= '0;
            frame_r     <= frame_next_s;
            word_r      <= msg_word(msg_r, frame_next_s);
            state_r     <= ST_LOAD;
          end else if (tick_ok_s) begin
            shift_cnt_r <= shift_cnt_r + {{(SW-1){1'b0}}, 1'b1};
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_r <= ST_RUN;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Mode decode; the shift mode must react to pause/stop in the tick cycle itself.
  always_comb begin
    mode_s = MODE_HOLD;
    if (rst) begin
      mode_s = MODE_HOLD;
    end else begin
      case (state_r)
        ST_LOAD: mode_s = MODE_LOAD;
        ST_RUN: begin
          if (tick_ok_s) begin
            mode_s = dir ? MODE_SHL : MODE_SHR;
          end else begin
            mode_s = MODE_HOLD;
          end
        end
        default: mode_s = MODE_HOLD;
      endcase
    end
  end

  assign {ch1, ch0}   = mode_s;
  assign cadeiaDeBits = word_r;
  assign busy         = (state_r != ST_IDLE);
  assign frame_done   = last_shift_s;

endmodule

// File: tb/tb_controle_painel.sv
// Directed bench for controle_painel with TICK_DIV=4, SHIFTS_PER_FRAME=3.
module tb_controle_painel;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause, dir;
  logic [1:0]  msg_sel;
  logic        ch0, ch1, busy, frame_done;
  logic [15:0] cadeiaDeBits;
  logic [1:0]  mode;
  int passed = 0;
  int total  = 0;

  assign mode = {ch1, ch0};

  controle_painel #(.TICK_DIV(4), .SHIFTS_PER_FRAME(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .dir(dir),
    .msg_sel(msg_sel), .ch0(ch0), .ch1(ch1), .cadeiaDeBits(cadeiaDeBits),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_word(input int m, input int f);
    case (m * 4 + f)
      0: return 16'h1111;   1: return 16'h2222;   2: return 16'h3333;   3: return 16'h4444;
      4: return 16'hA001;   5: return 16'hA002;   6: return 16'hA003;   7: return 16'hA004;
      8: return 16'hB0F0;   9: return 16'hB1F1;  10: return 16'hB2F2;  11: return 16'hB3F3;
      12: return 16'hC3C3; 13: return 16'h3C3C;  14: return 16'hF00F;  15: return 16'h0FF0;
      default: return 16'hxxxx;
    endcase
  endfunction

  // Advance to just after the next rising edge; checks wait for the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [1:0] m, input logic d);
    msg_sel = m; dir = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0; msg_sel = 2'd0;
    step(); step();
    @(negedge clk);
    total++; if (mode !== 2'b00) $display("FAIL rst_mode got %b want 00", mode); else passed++;
    total++; if (cadeiaDeBits !== 16'h0000) $display("FAIL rst_word got %h want 0000", cadeiaDeBits); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL rst_fd got %b want 0", frame_done); else passed++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_first_load();
    msg_sel = 2'd2; start = 1'b1;
    @(negedge clk);
    total++; if (mode !== 2'b00 || busy !== 1'b0) $display("FAIL s1_idle got mode=%b busy=%b want 00/0", mode, busy); else passed++;
    step();
    start = 1'b0;
    @(negedge clk);
    total++; if (mode !== 2'b11) $display("FAIL s1_load_mode got %b want 11", mode); else passed++;
    total++; if (cadeiaDeBits !== 16'hB0F0) $display("FAIL s1_load_word got %h want b0f0", cadeiaDeBits); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL s1_busy got %b want 1", busy); else passed++;
    for (int k = 1; k <= 4; k++) begin
      step();
      @(negedge clk);
      total++;
      if (mode !== ((k == 4) ? 2'b01 : 2'b00)) $display("FAIL s1_cycle%0d mode got %b want %b", k, mode, (k == 4) ? 2'b01 : 2'b00);
      else passed++;
    end
    step();
    do_stop();
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL s1_stop_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_frames_left();
    int fd_cnt = 0;
    start_msg(2'd1, 1'b1);
    for (int f = 0; f < 12; f++) begin
      @(negedge clk);
      total++; if (mode !== 2'b11) $display("FAIL s2_load_mode f%0d got %b want 11", f, mode); else passed++;
      total++; if (cadeiaDeBits !== exp_word(1, f % 4)) $display("FAIL s2_word f%0d got %h want %h", f, cadeiaDeBits, exp_word(1, f % 4)); else passed++;
      step();
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (frame_done === 1'b1) fd_cnt++;
        total++;
        if (mode !== ((k % 4 == 0) ? 2'b10 : 2'b00)) $display("FAIL s2_mode f%0d c%0d got %b want %b", f, k, mode, (k % 4 == 0) ? 2'b10 : 2'b00);
        else passed++;
        total++;
        if (frame_done !== (k == 12)) $display("FAIL s2_fd f%0d c%0d got %b want %b", f, k, frame_done, (k == 12));
        else passed++;
        step();
      end
    end
    total++; if (fd_cnt != 12) $display("FAIL s2_fd_count got %0d want 12", fd_cnt); else passed++;
    do_stop();
  endtask

  task automatic test_pause_on_tick();
    start_msg(2'd0, 1'b0);
    repeat (4) step();
    pause = 1'b1;
    @(negedge clk);
    total++; if (mode !== 2'b00 || frame_done !== 1'b0) $display("FAIL s3_tick_suppr got mode=%b fd=%b want 00/0", mode, frame_done); else passed++;
    step();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      total++; if (mode !== 2'b00 || busy !== 1'b1) $display("FAIL s3_paused c%0d got mode=%b busy=%b want 00/1", k, mode, busy); else passed++;
      step();
    end
    pause = 1'b0;
    @(negedge clk);
    total++; if (mode !== 2'b00) $display("FAIL s3_unpause got %b want 00", mode); else passed++;
    step();
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (mode !== ((k % 4 == 0) ? 2'b01 : 2'b00)) $display("FAIL s3_resume c%0d mode got %b want %b", k, mode, (k % 4 == 0) ? 2'b01 : 2'b00);
      else passed++;
      total++;
      if (frame_done !== (k == 8)) $display("FAIL s3_resume c%0d fd got %b want %b", k, frame_done, (k == 8));
      else passed++;
      step();
    end
    @(negedge clk);
    total++; if (mode !== 2'b11 || cadeiaDeBits !== 16'h2222) $display("FAIL s3_next_load got %b/%h want 11/2222", mode, cadeiaDeBits); else passed++;
    do_stop();
  endtask

  task automatic test_stop_priority();
    start_msg(2'd3, 1'b0);
    repeat (4) step();
    stop = 1'b1; start = 1'b1; pause = 1'b1;
    @(negedge clk);
    total++; if (mode !== 2'b00 || frame_done !== 1'b0) $display("FAIL s4_tick_cycle got mode=%b fd=%b want 00/0", mode, frame_done); else passed++;
    step();
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL s4_busy got %b want 0", busy); else passed++;
    total++; if (mode !== 2'b00) $display("FAIL s4_mode got %b want 00", mode); else passed++;
    total++; if (cadeiaDeBits !== 16'hC3C3) $display("FAIL s4_word_hold got %h want c3c3", cadeiaDeBits); else passed++;
    stop = 1'b0; start = 1'b0; pause = 1'b0;
    step();
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL s4_stay_idle got %b want 0", busy); else passed++;
    step();
  endtask

  task automatic test_restart_ignored();
    start_msg(2'd0, 1'b0);
    step(); step();
    start = 1'b1; msg_sel = 2'd3;
    @(negedge clk);
    total++; if (mode !== 2'b00) $display("FAIL s5_restart_cycle got %b want 00", mode); else passed++;
    step();
    start = 1'b0;
    @(negedge clk);
    total++; if (mode !== 2'b00 || busy !== 1'b1) $display("FAIL s5_no_reload got mode=%b busy=%b want 00/1", mode, busy); else passed++;
    repeat (9) step();
    @(negedge clk);
    total++; if (frame_done !== 1'b1 || mode !== 2'b01) $display("FAIL s5_frame_end got fd=%b mode=%b want 1/01", frame_done, mode); else passed++;
    step();
    @(negedge clk);
    total++; if (mode !== 2'b11 || cadeiaDeBits !== 16'h2222) $display("FAIL s5_next_load got %b/%h want 11/2222", mode, cadeiaDeBits); else passed++;
    do_stop();
  endtask

  task automatic test_reset_in_load();
    start_msg(2'd2, 1'b0);
    repeat (13) step();
    @(negedge clk);
    total++; if (mode !== 2'b11 || cadeiaDeBits !== 16'hB1F1) $display("FAIL s6_frame1 got %b/%h want 11/b1f1", mode, cadeiaDeBits); else passed++;
    step();
    rst = 1'b1;
    @(negedge clk);
    total++; if (mode !== 2'b00) $display("FAIL s6_rst_mode got %b want 00", mode); else passed++;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mode !== 2'b00 || cadeiaDeBits !== 16'h0000 || busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL s6_after_rst got mode=%b word=%h busy=%b fd=%b want 00/0000/0/0", mode, cadeiaDeBits, busy, frame_done);
    else passed++;
    step(); step();
    @(negedge clk);
    total++; if (mode !== 2'b00 || busy !== 1'b0) $display("FAIL s6_idle got mode=%b busy=%b want 00/0", mode, busy); else passed++;
    start_msg(2'd2, 1'b0);
    @(negedge clk);
    total++; if (mode !== 2'b11 || cadeiaDeBits !== 16'hB0F0) $display("FAIL s6_reload got %b/%h want 11/b0f0", mode, cadeiaDeBits); else passed++;
    do_stop();
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_frames_left();
    test_pause_on_tick();
    test_stop_priority();
    test_restart_ignored();
    test_reset_in_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
